// File: rtl/spi_pkg.sv
// Shared definitions for spi_master: FSM state encoding, command-type codes and frame lengths.
package spi_pkg;

    typedef logic [1:0] cmd_type_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SHIFT = 3'd1;
    localparam logic [2:0] ST_TURN  = 3'd2;
    localparam logic [2:0] ST_RECV  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    localparam cmd_type_t CMD_WR_ADDR = 2'b00;
    localparam cmd_type_t CMD_WR_DATA = 2'b01;
    localparam cmd_type_t CMD_RD_ADDR = 2'b10;
    localparam cmd_type_t CMD_RD_DATA = 2'b11;

    localparam int unsigned FRAME_OUT_LEN = 10;
    localparam int unsigned FRAME_IN_LEN  = 8;

    // Only read-data commands are followed by a turnaround and a returned byte.
    function automatic logic is_read_data(input cmd_type_t cmd_type);
        return cmd_type == CMD_RD_DATA;
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// Host command/response handshake plus the SPI pins of spi_master, bundled as one interface.
interface spi_master_if;
    import spi_pkg::*;

    logic                     cmd_valid;
    logic [FRAME_OUT_LEN-1:0] cmd_data;
    logic                     cmd_ready;
    logic                     rsp_valid;
    logic [FRAME_IN_LEN-1:0]  rsp_data;
    logic                     busy;
    logic                     SS_n;
    logic                     MOSI;
    logic                     MISO;

    modport master (
        input  cmd_valid, cmd_data, MISO,
        output cmd_ready, rsp_valid, rsp_data, busy, SS_n, MOSI
    );

    modport slave (
        output cmd_valid, cmd_data, MISO,
        input  cmd_ready, rsp_valid, rsp_data, busy, SS_n, MOSI
    );

endinterface

// File: rtl/spi_master_shreg.sv
// 10-bit frame shift register: parallel load, serial out from the MSB, serial in at the LSB.
module spi_master_shreg
    import spi_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_load,
    input  logic [FRAME_OUT_LEN-1:0] i_load_data,
    input  logic                     i_shift,
    input  logic                     i_ser_in,
    output logic                     o_ser_out,
    output logic [FRAME_IN_LEN-1:0]  o_byte_next
);

    logic [FRAME_OUT_LEN-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_load_data;
        end else if (i_shift) begin
            r_data <= {r_data[FRAME_OUT_LEN-2:0], i_ser_in};
        end
    end

    assign o_ser_out   = r_data[FRAME_OUT_LEN-1];
    // Received byte as it will read once the current shift-in completes.
    assign o_byte_next = {r_data[FRAME_IN_LEN-2:0], i_ser_in};

endmodule

// File: rtl/spi_master.sv
// SPI command master: 10-bit command frame out, optional turnaround plus 8-bit read-back.
// Optional abort input enabled by defining SPI_MASTER_ABORT_EN.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned TURNAROUND = 2
) (
    input  logic clk,
    input  logic rst,
`ifdef SPI_MASTER_ABORT_EN
    input  logic abort,
`endif
    spi_master_if.master bus
);

    localparam logic [3:0] OUT_LAST  = 4'(FRAME_OUT_LEN - 1);
    localparam logic [3:0] IN_LAST   = 4'(FRAME_IN_LEN - 1);
    localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);

    logic [2:0]              r_state;
    logic [2:0]              w_state_next;
    logic [3:0]              r_bit_cnt;
    logic [3:0]              w_bit_cnt_next;
    cmd_type_t               r_cmd_type;
    logic                    r_ready_en;
    logic                    r_rsp_valid;
    logic [FRAME_IN_LEN-1:0] r_rsp_data;
    logic                    w_accept;
    logic                    w_load;
    logic                    w_shift;
    logic                    w_rsp_load;
    logic                    w_ser_out;
    logic [FRAME_IN_LEN-1:0] w_byte_next;

    assign w_accept = bus.cmd_valid && bus.cmd_ready;

    // Counter is reloaded with (length-1) on every state entry and leaves the state at zero.
    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_load         = 1'b0;
        w_shift        = 1'b0;
        w_rsp_load     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next   = ST_SHIFT;
                    w_bit_cnt_next = OUT_LAST;
                    w_load         = 1'b1;
                end
            end
            ST_SHIFT: begin
                w_shift = 1'b1;
                if (r_bit_cnt == 4'd0) begin
                    if (is_read_data(r_cmd_type)) begin
                        w_state_next   = ST_TURN;
                        w_bit_cnt_next = TURN_LAST;
                    end else begin
                        w_state_next   = ST_GAP;
                        w_bit_cnt_next = 4'd0;
                    end
                end else begin
                    w_bit_cnt_next = r_bit_cnt - 4'd1;
                end
            end
            ST_TURN: begin
                if (r_bit_cnt == 4'd0) begin
                    w_state_next   = ST_RECV;
                    w_bit_cnt_next = IN_LAST;
                end else begin
                    w_bit_cnt_next = r_bit_cnt - 4'd1;
                end
            end
            ST_RECV: begin
                w_shift = 1'b1;
                if (r_bit_cnt == 4'd0) begin
                    w_state_next   = ST_GAP;
                    w_bit_cnt_next = 4'd0;
                    w_rsp_load     = 1'b1;
                end else begin
                    w_bit_cnt_next = r_bit_cnt - 4'd1;
                end
            end
            ST_GAP: begin
                w_state_next   = ST_IDLE;
                w_bit_cnt_next = 4'd0;
            end
            default: begin
                w_state_next   = ST_IDLE;
                w_bit_cnt_next = 4'd0;
            end
        endcase
`ifdef SPI_MASTER_ABORT_EN
        if (abort && (r_state == ST_SHIFT || r_state == ST_TURN || r_state == ST_RECV)) begin
            w_state_next   = ST_GAP;
            w_bit_cnt_next = 4'd0;
            w_shift        = 1'b0;
            w_rsp_load     = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 4'd0;
            r_cmd_type  <= CMD_WR_ADDR;
            r_ready_en  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_ready_en  <= 1'b1;
            r_rsp_valid <= w_rsp_load;
            if (w_load) begin
                r_cmd_type <= bus.cmd_data[FRAME_OUT_LEN-1 -: 2];
            end
            if (w_rsp_load) begin
                r_rsp_data <= w_byte_next;
            end
        end
    end

    spi_master_shreg u_shreg (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_load_data (bus.cmd_data),
        .i_shift     (w_shift),
        .i_ser_in    (bus.MISO),
        .o_ser_out   (w_ser_out),
        .o_byte_next (w_byte_next)
    );

    // r_ready_en keeps cmd_ready low during the first cycle after reset is released.
    assign bus.cmd_ready = (r_state == ST_IDLE) && r_ready_en;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.SS_n      = !(r_state == ST_SHIFT || r_state == ST_TURN || r_state == ST_RECV);
    assign bus.MOSI      = (r_state == ST_SHIFT) ? w_ser_out : 1'b0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_spi_master.sv
// Randomized scoreboard bench for spi_master with a behavioural SPI slave model.
module tb_spi_master;
    import spi_pkg::*;

    localparam int T      = 2;
    localparam int RD_LAT = 10 + T + 8 + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef SPI_MASTER_ABORT_EN
    logic abort = 1'b0;
`endif

    spi_master_if bus();

    spi_master #(.TURNAROUND(T)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef SPI_MASTER_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard queues: filled by the stimulus, drained by the monitor/slave.
    logic [9:0] frame_q[$];
    logic [7:0] miso_q[$];
    logic [7:0] rsp_q[$];
    int         acc_q[$];

    int         cyc = 0;
    int         n_acc = 0;
    int         rsp_seen = 0;
    int         high_run = 0;
    int         last_gap = 0;
    int         idx = 0;
    bit         skip_frame = 1'b0;
    bit         prev_rsp = 1'b0;
    logic [9:0] bits = '0;
    logic [7:0] cur_byte = '0;
    logic [7:0] last_rsp_model = '0;

    function automatic void check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor and slave model, both sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_rsp       = 1'b0;
            last_rsp_model = '0;
            idx            = 0;
            bits           = '0;
            bus.MISO       = 1'b0;
        end else begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                n_acc++;
                if (bus.cmd_data[9:8] == CMD_RD_DATA) acc_q.push_back(cyc);
            end
            if (bus.rsp_valid) begin
                rsp_seen++;
                check("rsp_pulse_width", prev_rsp, 0);
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    last_rsp_model = rsp_q.pop_front();
                    check("rsp_data", bus.rsp_data, last_rsp_model);
                    if (acc_q.size() != 0) check("rsp_latency", cyc - acc_q.pop_front(), RD_LAT);
                end
            end else begin
                check("rsp_data_hold", bus.rsp_data, last_rsp_model);
            end
            prev_rsp = bus.rsp_valid;
            if (!bus.SS_n) begin
                check("busy_while_selected", bus.busy, 1);
                check("ready_while_selected", bus.cmd_ready, 0);
            end else begin
                check("mosi_idle", bus.MOSI, 0);
            end

            // Slave: clocks in 10 command bits, waits T cycles, returns a byte for read-data.
            if (!bus.SS_n) begin
                if (high_run > 0) begin
                    last_gap = high_run;
                    high_run = 0;
                end
                if (idx < 10) bits = {bits[8:0], bus.MOSI};
                if (idx >= 10 + T && idx < 18 + T && bits[9:8] == CMD_RD_DATA) begin
                    if (idx == 10 + T) cur_byte = (miso_q.size() != 0) ? miso_q.pop_front() : 8'h00;
                    bus.MISO = cur_byte[7 - (idx - 10 - T)];
                end else begin
                    bus.MISO = 1'b0;
                end
                idx++;
            end else begin
                if (idx > 0 && !skip_frame) begin
                    if (frame_q.size() == 0) begin
                        check("frame_unexpected", 1, 0);
                    end else begin
                        logic [9:0] exp_frame;
                        exp_frame = frame_q.pop_front();
                        check("mosi_frame", bits, exp_frame);
                        check("frame_len", idx, (exp_frame[9:8] == CMD_RD_DATA) ? 18 + T : 10);
                    end
                end
                idx      = 0;
                high_run++;
                bus.MISO = 1'b0;
            end
        end
    end

    task automatic wait_accept(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.cmd_ready && k < 100);
        if (!bus.cmd_ready) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(bus.cmd_ready && !bus.busy) && k < 100);
        if (k >= 100) check("idle_timeout", 0, 1);
    endtask

    task automatic send(input logic [9:0] cmd, input logic [7:0] rbyte);
        int k;
        frame_q.push_back(cmd);
        if (cmd[9:8] == CMD_RD_DATA) begin
            miso_q.push_back(rbyte);
            rsp_q.push_back(rbyte);
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = cmd;
        wait_accept(k);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic clear_queues();
        frame_q.delete();
        miso_q.delete();
        rsp_q.delete();
        acc_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int a0;
        int seen0;
        cmd_type_t ty;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ss_n", bus.SS_n, 1);
        check("rst_mosi", bus.MOSI, 0);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_busy", bus.busy, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("ready_release_cycle", bus.cmd_ready, 0);
        @(negedge clk);
        check("ready_after_release", bus.cmd_ready, 1);

        // Directed: write-addr and read-data
        send(10'h0A5, 8'h00);
        wait_idle();
        send(10'h300, 8'hC3);
        wait_idle();
        check("rd_c3_count", rsp_seen, 1);

        // Back-to-back with cmd_valid held high
        frame_q.push_back(10'h1FF);
        frame_q.push_back(10'h2AA);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 10'h1FF;
        wait_accept(k);
        @(posedge clk); #1;
        bus.cmd_data  = 10'h2AA;
        wait_accept(k);
        check("b2b_spacing", k, 12);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        wait_idle();
        check("b2b_ss_high_gap", last_gap, 2);

        // cmd_valid pulsed during SHIFT must be ignored
        a0 = n_acc;
        send(10'h155, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 10'h3FF;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("shift_pulse_ignored", n_acc - a0, 1);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(3, 0))
                0:       ty = CMD_WR_ADDR;
                1:       ty = CMD_WR_DATA;
                2:       ty = CMD_RD_ADDR;
                default: ty = CMD_RD_DATA;
            endcase
            send({ty, 8'($urandom)}, 8'($urandom));
            repeat ($urandom_range(3, 0)) @(posedge clk);
        end
        wait_idle();
        repeat (4) @(negedge clk);
        check("drain_frames", frame_q.size(), 0);
        check("drain_rsp", rsp_q.size(), 0);

        // Reset in the middle of RECV (bit 4)
        send(10'h3C0, 8'h5A);
        k = 0;
        do begin
            @(posedge clk);
            k++;
        end while (idx != 10 + T + 4 && k < 100);
        check("reach_recv_bit4", idx, 10 + T + 4);
        #1;
        rst = 1'b1;
        clear_queues();
        seen0 = rsp_seen;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_ss_n", bus.SS_n, 1);
        check("midrst_busy", bus.busy, 0);
        check("midrst_ready_low", bus.cmd_ready, 0);
        check("midrst_rsp_data", bus.rsp_data, 0);
        @(negedge clk);
        check("midrst_ready_high", bus.cmd_ready, 1);
        repeat (30) @(negedge clk);
        check("midrst_no_rsp", rsp_seen - seen0, 0);

`ifdef SPI_MASTER_ABORT_EN
        // Abort during TURN: GAP next cycle, no response, then IDLE
        skip_frame = 1'b1;
        seen0 = rsp_seen;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 10'h3A5;
        wait_accept(k);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        k = 0;
        do begin
            @(posedge clk);
            k++;
        end while (idx != 10 && k < 100);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_ss_n", bus.SS_n, 1);
        check("abort_gap_busy", bus.busy, 1);
        check("abort_rsp_valid", bus.rsp_valid, 0);
        check("abort_rsp_data", bus.rsp_data, last_rsp_model);
        @(negedge clk);
        check("abort_idle_ready", bus.cmd_ready, 1);
        repeat (25) @(negedge clk);
        check("abort_no_rsp", rsp_seen - seen0, 0);
        skip_frame = 1'b0;
        clear_queues();
`endif

        // One more read after the disturbances
        send(10'h3FF, 8'h96);
        wait_idle();
        repeat (4) @(negedge clk);
        check("final_rsp_drain", rsp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter TURNAROUND, default 2: idle cycles, SS_n held low, between the last MOSI bit and the first sampled MISO bit of a read-data transaction (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: the host offers a command word.
REQ-005 SHALL have port cmd_data, input, 10 bits: [9:8] is the command type (00 write-addr, 01 write-data, 10 read-addr, 11 read-data); [7:0] is the payload.
REQ-006 SHALL have port cmd_ready, output, 1 bit: the master accepts cmd_data this cycle.
REQ-007 SHALL have port rsp_valid, output, 1 bit: a one-cycle pulse meaning rsp_data holds a read byte.
REQ-008 SHALL have port rsp_data, output, 8 bits: the byte returned by the slave.
REQ-009 SHALL have port busy, output, 1 bit: a transaction is in progress.
REQ-010 SHALL have port SS_n, output, 1 bit: slave select, active low.
REQ-011 SHALL have port MOSI, output, 1 bit: serial data to the slave, MSB first.
REQ-012 SHALL have port MISO, input, 1 bit: serial data from the slave, MSB first.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, TURN, RECV and GAP.
REQ-014 IDLE: cmd_ready=1, SS_n=1, MOSI=0, busy=0; on cmd_valid&&cmd_ready it SHALL latch cmd_data and go to SHIFT.
REQ-015 SHIFT: SS_n=0 and busy=1 for exactly 10 cycles, with MOSI driving latched bits 9 down to 0, one bit per cycle; bit 9 is the read/write select seen by the slave in its command-check state.
REQ-016 After SHIFT the FSM SHALL go to TURN when latched[9:8]==2'b11, otherwise to GAP.
REQ-017 TURN: SS_n=0, MOSI=0 for TURNAROUND cycles, then go to RECV.
REQ-018 RECV: SS_n=0 for 8 cycles, sampling MISO into the shift register MSB first; on the 8th sample it SHALL go to GAP.
REQ-019 rsp_valid SHALL pulse high for exactly one cycle, on the first GAP cycle after RECV, with rsp_data valid in that cycle; rsp_data SHALL hold its value until the next read completes.
REQ-020 GAP: SS_n=1, cmd_ready=0, busy=1 for exactly 1 cycle, then go to IDLE.
REQ-021 The minimum SS_n-high time between transactions SHALL be 2 cycles (GAP plus IDLE).
REQ-022 Latency from acceptance to rsp_valid SHALL be 10+TURNAROUND+8+1 cycles.
REQ-023 cmd_valid SHALL be ignored outside IDLE, and cmd_ready SHALL be 0 outside IDLE.
REQ-024 Bit counter SHALL be 4 bits and reloaded on each state entry, with no wrap-around beyond its terminal count.

Reset
REQ-025 On rst=1 at a clock edge: state=IDLE, SS_n=1, MOSI=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=0, counters=0.
REQ-026 cmd_ready SHALL first rise in the cycle after rst deasserts.
REQ-027 Reset mid-transaction SHALL drop the transfer with no rsp_valid and raise SS_n at the next edge.

Configuration
REQ-028 With SPI_MASTER_ABORT_EN defined, the block SHALL add input abort (1 bit); abort=1 in SHIFT, TURN or RECV forces GAP at the next edge, with SS_n=1, no rsp_valid, and rsp_data unchanged.
REQ-029 With SPI_MASTER_ABORT_EN undefined, the abort port and its logic SHALL not exist, and behaviour SHALL be identical to abort tied 0.

Structure
REQ-030 Package spi_pkg SHALL hold the state encoding, the command-type constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11, and the frame lengths (10 out, 8 in).
REQ-031 A single sub-module spi_master_shreg (10-bit parallel load, shift out MSB, shift in LSB) SHALL be used; the FSM and counters SHALL remain in spi_master.

Verification
REQ-032 Write-addr: cmd_data=10'h0A5 -> SS_n low 10 cycles, MOSI sequence 0,0,1,0,1,0,0,1,0,1, then SS_n high, and no rsp_valid.
REQ-033 Read-data: cmd_data=10'h300 with the slave model returning 8'hC3 -> after 10+2 cycles, 8 MISO samples, then rsp_valid=1 for one cycle with rsp_data=8'hC3, 21 cycles after acceptance.
REQ-034 Back-to-back: cmd_valid held high with 10'h1FF then 10'h2AA -> second acceptance exactly 12 cycles after the first, with SS_n high for 2 cycles between the transactions.
REQ-035 Reset mid-RECV: rst=1 at RECV bit 4 -> SS_n=1 next edge, rsp_valid never asserted, cmd_ready=1 the cycle after release.
REQ-036 cmd_valid pulsed during SHIFT -> ignored; MOSI stream unchanged and no extra transaction.
REQ-037 With SPI_MASTER_ABORT_EN: abort during TURN -> GAP next cycle, SS_n=1, rsp_valid stays 0, then IDLE.
